// File: rtl/data_mem_responder_if.sv
// ---------------------------------------------------------------------------
// data_mem_responder_if
//   Request/acknowledge signals of the CPU data-memory bus.
//   The bidirectional data bus DDT is not carried here. It stays a discrete
//   inout port on the responder, so tristate resolution happens on an
//   ordinary module net.
//
//   MREQ      initiator -> responder  read request, active-high
//   WRITE     initiator -> responder  write request, active-high (wins over MREQ)
//   SIZE      initiator -> responder  00 byte, 01 half, 10/11 word
//   DAD       initiator -> responder  byte address
//   ACKD_n    responder -> initiator  one-cycle active-low acknowledge
//   ALIGN_ERR responder -> initiator  misaligned-access flag, valid with ACKD_n
// ---------------------------------------------------------------------------
interface data_mem_responder_if;
  logic        MREQ;
  logic        WRITE;
  logic [1:0]  SIZE;
  logic [31:0] DAD;
  logic        ACKD_n;
  logic        ALIGN_ERR;

  modport master (output MREQ, WRITE, SIZE, DAD, input ACKD_n, ALIGN_ERR);
  modport slave  (input MREQ, WRITE, SIZE, DAD, output ACKD_n, ALIGN_ERR);
endinterface

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//   Data-memory slave for the CPU data bus. It accepts byte, half and word
//   requests, backs them with a synchronous word RAM, and inserts WAIT_CYCLES
//   wait states. It then acknowledges with a single-cycle active-low ACKD_n.
//   The RAM is built as four byte lanes so that sub-word writes need no
//   read-modify-write.
//
// Parameters
//   ADDR_WIDTH   word-address bits, depth = 2**ADDR_WIDTH words
//   WAIT_CYCLES  wait states between accept and ACK (0..15)
//
// Ports
//   clk   in     rising-edge clock
//   rst   in     synchronous active-high reset
//   bus   slave  MREQ/WRITE/SIZE/DAD in, ACKD_n/ALIGN_ERR out
//   DDT   inout  data bus. The initiator drives write data. The responder
//                drives read data only in a read ACK cycle; otherwise 'z.
//
// Build option
//   DMEM_ALIGN_CHECK_EN  When defined, misaligned half/word accesses are still
//                        ACKed, but no write happens, reads return 0, and
//                        ALIGN_ERR is high during ACK. When undefined, the low
//                        address bits are forced aligned and ALIGN_ERR is 0.
// ---------------------------------------------------------------------------
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus,
  inout  wire  [31:0]          DDT
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_ACK = 2'd2} state_t;

  state_t                  state_q;
  logic [3:0]              cnt_q;
  logic                    ackd_n_q, drive_q, align_err_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [1:0]              lo_q, size_q;
  logic                    wr_q, misalign_q;
  logic [31:0]             wdata_q;

  // Request decode straight off the bus; these values are latched on accept.
  logic                    req;
  logic [ADDR_WIDTH-1:0]   idx_d;
  logic [1:0]              lo_d, size_d;
  logic                    wr_d, misalign_d;
  logic [31:0]             wdata_d;

  assign req     = bus.MREQ | bus.WRITE;
  assign idx_d   = bus.DAD[ADDR_WIDTH+1:2];   // upper address bits alias
  assign size_d  = bus.SIZE;
  assign wr_d    = bus.WRITE;
  assign wdata_d = DDT;

`ifdef DMEM_ALIGN_CHECK_EN
  assign lo_d = bus.DAD[1:0];
  always_comb begin
    misalign_d = 1'b0;
    if (bus.SIZE == 2'b01)  misalign_d = bus.DAD[0];
    else if (bus.SIZE[1])   misalign_d = (bus.DAD[1:0] != 2'b00);
  end
`else
  always_comb begin
    lo_d = bus.DAD[1:0];
    if (bus.SIZE == 2'b01)  lo_d[0] = 1'b0;
    else if (bus.SIZE[1])   lo_d = 2'b00;
  end
  assign misalign_d = 1'b0;
`endif

  logic unused_dad;
  assign unused_dad = ^bus.DAD[31:ADDR_WIDTH+2];

  // With zero wait states, the RAM access happens on the accept edge itself.
  // In that case the access must use the live bus values rather than the
  // latched copies.
  logic                  from_bus;
  logic [ADDR_WIDTH-1:0] cur_idx;
  logic [1:0]            cur_lo, cur_size;
  logic                  cur_wr, cur_misalign;
  logic [31:0]           cur_wdata;

  assign from_bus     = (state_q == S_IDLE);
  assign cur_idx      = from_bus ? idx_d      : idx_q;
  assign cur_lo       = from_bus ? lo_d       : lo_q;
  assign cur_size     = from_bus ? size_d     : size_q;
  assign cur_wr       = from_bus ? wr_d       : wr_q;
  assign cur_misalign = from_bus ? misalign_d : misalign_q;
  assign cur_wdata    = from_bus ? wdata_d    : wdata_q;

  // This edge moves the FSM into ACK: the write commits and the read data
  // registers on it.
  logic enter_ack;
  assign enter_ack = (state_q == S_IDLE) ? (req && (WAIT_CYCLES == 0))
                                         : ((state_q == S_WAIT) && (cnt_q == 4'd1));

  logic [3:0]  be;
  logic [31:0] wlane;
  always_comb begin
    case (cur_size)
      2'b00:   be = 4'b0001 << cur_lo;
      2'b01:   be = cur_lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    // Right-aligned write data is replicated, so every lane sees its byte.
    case (cur_size)
      2'b00:   wlane = {4{cur_wdata[7:0]}};
      2'b01:   wlane = {2{cur_wdata[15:0]}};
      default: wlane = cur_wdata;
    endcase
  end

  // rst gates the write, so a reset during WAIT aborts the access cleanly.
  logic mem_we;
  assign mem_we = enter_ack & cur_wr & ~cur_misalign & ~rst;

  logic [31:0] rword;
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_q;
      always_ff @(posedge clk) begin
        if (mem_we && be[gi]) mem[cur_idx] <= wlane[8*gi +: 8];
        if (enter_ack)        rd_q <= mem[cur_idx];
      end
      assign rword[8*gi +: 8] = rd_q;
    end
  endgenerate

  // Read data is zero-extended; the core does any sign extension.
  logic [31:0] rdata_fmt;
  always_comb begin
    rdata_fmt = rword;
    case (size_q)
      2'b00: begin
        case (lo_q)
          2'd0:    rdata_fmt = {24'h0, rword[7:0]};
          2'd1:    rdata_fmt = {24'h0, rword[15:8]};
          2'd2:    rdata_fmt = {24'h0, rword[23:16]};
          default: rdata_fmt = {24'h0, rword[31:24]};
        endcase
      end
      2'b01:   rdata_fmt = lo_q[1] ? {16'h0, rword[31:16]} : {16'h0, rword[15:0]};
      default: rdata_fmt = rword;
    endcase
    if (align_err_q) rdata_fmt = 32'h0;
  end

  assign DDT           = drive_q ? rdata_fmt : 'z;
  assign bus.ACKD_n    = ackd_n_q;
  assign bus.ALIGN_ERR = align_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      ackd_n_q    <= 1'b1;
      drive_q     <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      ackd_n_q    <= ~enter_ack;
      drive_q     <= enter_ack & ~cur_wr;
      align_err_q <= enter_ack & cur_misalign;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            idx_q      <= idx_d;
            lo_q       <= lo_d;
            size_q     <= size_d;
            wr_q       <= wr_d;
            misalign_q <= misalign_d;
            wdata_q    <= wdata_d;
            if (WAIT_CYCLES == 0) begin
              state_q <= S_ACK;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= 4'(WAIT_CYCLES);
            end
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= S_ACK;
        end
        S_ACK:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
//   Two responders share one clock and reset: dut0 has WAIT_CYCLES=2 and dut1
//   has WAIT_CYCLES=0. Directed vectors are applied from tables. Hand-written
//   sequences cover reset during WAIT and back-to-back acknowledges.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;
  localparam int AW = 10;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALN = 1'b1;
`else
  localparam bit ALN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int checks   = 0;
  int failures = 0;

  data_mem_responder_if bus0();
  data_mem_responder_if bus1();
  wire [31:0] ddt0, ddt1;

  logic [1:0]  mreq, wrt, drv_en;
  logic [1:0]  size [2];
  logic [31:0] dad [2];
  logic [31:0] drv_val [2];
  logic [1:0]  ack_n, aerr;
  logic [31:0] ddt_rd [2];

  assign bus0.MREQ  = mreq[0];
  assign bus0.WRITE = wrt[0];
  assign bus0.SIZE  = size[0];
  assign bus0.DAD   = dad[0];
  assign bus1.MREQ  = mreq[1];
  assign bus1.WRITE = wrt[1];
  assign bus1.SIZE  = size[1];
  assign bus1.DAD   = dad[1];
  assign ddt0 = drv_en[0] ? drv_val[0] : 'z;
  assign ddt1 = drv_en[1] ? drv_val[1] : 'z;
  assign ack_n     = {bus1.ACKD_n, bus0.ACKD_n};
  assign aerr      = {bus1.ALIGN_ERR, bus0.ALIGN_ERR};
  assign ddt_rd[0] = ddt0;
  assign ddt_rd[1] = ddt1;

  data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .DDT(ddt0));
  data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .DDT(ddt1));

  typedef struct {
    int          k;
    bit          wr;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_aerr;
  } vec_t;

  function automatic vec_t mk(int k, bit wr, logic [1:0] sz, logic [31:0] a,
                              logic [31:0] d, logic [31:0] e, bit ae);
    vec_t v;
    v.k = k; v.wr = wr; v.sz = sz; v.addr = a; v.wdata = d; v.exp_rd = e; v.exp_aerr = ae;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Starts on a negedge with the DUT idle. Returns on a negedge one cycle
  // after the ACK pulse.
  task automatic run_vec(input vec_t v, input int id);
    int k    = v.k;
    int lat  = (k == 0) ? 3 : 1;
    int seen = 0;
    mreq[k] = 1'b1;  wrt[k] = v.wr;  size[k] = v.sz;  dad[k] = v.addr;
    drv_val[k] = v.wdata;  drv_en[k] = v.wr;
    @(posedge clk); #1;
    // Bus changes after the accept edge must not affect the access.
    dad[k] = ~v.addr;  drv_val[k] = ~v.wdata;  size[k] = ~v.sz;
    for (int n = 1; n <= 20 && seen == 0; n++) begin
      @(negedge clk);
      if (ack_n[k] == 1'b0) begin
        seen = n;
        check($sformatf("vec%0d latency", id), 32'(n), 32'(lat));
        check($sformatf("vec%0d align_err", id), 32'(aerr[k]), 32'(v.exp_aerr));
        if (!v.wr) check($sformatf("vec%0d rdata", id), ddt_rd[k], v.exp_rd);
        mreq[k] = 1'b0;  wrt[k] = 1'b0;  drv_en[k] = 1'b0;
      end
    end
    if (seen == 0) begin
      check($sformatf("vec%0d ack_timeout", id), 32'(0), 32'(lat));
      mreq[k] = 1'b0;  wrt[k] = 1'b0;  drv_en[k] = 1'b0;
    end
    @(negedge clk);
    check($sformatf("vec%0d ack_release", id), 32'(ack_n[k]), 32'(1));
    check($sformatf("vec%0d align_release", id), 32'(aerr[k]), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    vec_t va[$];
    vec_t vb[$];
    // Phase A: dut0 (3-cycle latency)
    va.push_back(mk(0, 1, 2'b10, 32'h10, 32'hDEADBEEF, 32'h0,        0));
    va.push_back(mk(0, 0, 2'b10, 32'h10, 32'h0,        32'hDEADBEEF, 0));
    va.push_back(mk(0, 0, 2'b00, 32'h13, 32'h0,        32'h000000DE, 0));
    va.push_back(mk(0, 1, 2'b00, 32'h20, 32'hFFFFFF11, 32'h0,        0));
    va.push_back(mk(0, 1, 2'b00, 32'h21, 32'h00000022, 32'h0,        0));
    va.push_back(mk(0, 1, 2'b00, 32'h22, 32'h00000033, 32'h0,        0));
    va.push_back(mk(0, 1, 2'b00, 32'h23, 32'h00000044, 32'h0,        0));
    va.push_back(mk(0, 0, 2'b10, 32'h20, 32'h0,        32'h44332211, 0));
    va.push_back(mk(0, 0, 2'b00, 32'h22, 32'h0,        32'h00000033, 0));
    va.push_back(mk(0, 0, 2'b01, 32'h22, 32'h0,        32'h00004433, 0));
    va.push_back(mk(0, 0, 2'b01, 32'h20, 32'h0,        32'h00002211, 0));
    va.push_back(mk(0, 1, 2'b10, 32'h30, 32'h01020304, 32'h0,        0));
    va.push_back(mk(0, 1, 2'b01, 32'h32, 32'h0000BEEF, 32'h0,        0));
    va.push_back(mk(0, 1, 2'b00, 32'h31, 32'h0000005A, 32'h0,        0));
    va.push_back(mk(0, 0, 2'b10, 32'h30, 32'h0,        32'hBEEF5A04, 0));
    va.push_back(mk(0, 1, 2'b11, 32'h40, 32'hA5A50F0F, 32'h0,        0));
    va.push_back(mk(0, 0, 2'b11, 32'h40, 32'h0,        32'hA5A50F0F, 0));
    va.push_back(mk(0, 1, 2'b10, 32'h08, 32'h11112222, 32'h0,        0));
    // Phase B: after reset abort, wrap, alignment, zero-wait dut1
    vb.push_back(mk(0, 0, 2'b10, 32'h08, 32'h0,        32'h11112222, 0));
    vb.push_back(mk(0, 1, 2'b10, (32'd4 << AW) + 32'h4, 32'h12345678, 32'h0, 0));
    vb.push_back(mk(0, 0, 2'b10, 32'h04, 32'h0,        32'h12345678, 0));
    vb.push_back(mk(0, 1, 2'b10, 32'h06, 32'h0BADCAFE, 32'h0,        ALN));
    vb.push_back(mk(0, 0, 2'b10, 32'h04, 32'h0,        ALN ? 32'h12345678 : 32'h0BADCAFE, 0));
    vb.push_back(mk(0, 0, 2'b10, 32'h05, 32'h0,        ALN ? 32'h0 : 32'h0BADCAFE, ALN));
    vb.push_back(mk(0, 0, 2'b01, 32'h23, 32'h0,        ALN ? 32'h0 : 32'h00004433, ALN));
    vb.push_back(mk(0, 0, 2'b01, 32'h21, 32'h0,        ALN ? 32'h0 : 32'h00002211, ALN));
    vb.push_back(mk(1, 1, 2'b10, 32'h00, 32'hA0A0A0A0, 32'h0,        0));
    vb.push_back(mk(1, 1, 2'b10, 32'h04, 32'hB1B1B1B1, 32'h0,        0));
    vb.push_back(mk(1, 0, 2'b00, 32'h05, 32'h0,        32'h000000B1, 0));
    vb.push_back(mk(1, 0, 2'b01, 32'h02, 32'h0,        32'h0000A0A0, 0));

    rst = 1'b1;  mreq = '0;  wrt = '0;  drv_en = '0;
    for (int k = 0; k < 2; k++) begin
      size[k] = 2'b00;  dad[k] = 32'h0;  drv_val[k] = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ack_n dut0", 32'(ack_n[0]), 32'(1));
    check("reset ack_n dut1", 32'(ack_n[1]), 32'(1));
    check("reset align_err dut0", 32'(aerr[0]), 32'(0));
    check("reset align_err dut1", 32'(aerr[1]), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    foreach (va[i]) run_vec(va[i], i);

    // Reset while a write sits in WAIT: no ACK, and memory keeps old data.
    mreq[0] = 1'b1;  wrt[0] = 1'b1;  size[0] = 2'b10;  dad[0] = 32'h8;
    drv_val[0] = 32'hCAFEF00D;  drv_en[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort wait ack_n", 32'(ack_n[0]), 32'(1));
    rst = 1'b1;  mreq[0] = 1'b0;  wrt[0] = 1'b0;  drv_en[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      check($sformatf("abort no_ack%0d", n), 32'(ack_n[0]), 32'(1));
      @(negedge clk);
    end

    foreach (vb[i]) run_vec(vb[i], 100 + i);

    // Zero-wait back-to-back reads; the held request is re-accepted in IDLE.
    mreq[1] = 1'b1;  size[1] = 2'b10;  dad[1] = 32'h0;
    @(posedge clk); #1;
    dad[1] = 32'h4;
    @(negedge clk);
    check("b2b ack1", 32'(ack_n[1]), 32'(0));
    check("b2b data1", ddt_rd[1], 32'hA0A0A0A0);
    @(negedge clk);
    check("b2b idle gap", 32'(ack_n[1]), 32'(1));
    @(negedge clk);
    check("b2b ack2", 32'(ack_n[1]), 32'(0));
    check("b2b data2", ddt_rd[1], 32'hB1B1B1B1);
    mreq[1] = 1'b0;
    @(negedge clk);
    check("b2b release", 32'(ack_n[1]), 32'(1));
    @(negedge clk);
    check("b2b stay idle", 32'(ack_n[1]), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
